// File: rtl/vector_stable_sync_if.sv
// Signal bundle between a vector source and the vector_stable_sync block.
// The source side (master) drives the raw vector and controls; the synchroniser (slave) returns the committed word.
interface vector_stable_sync_if #(
    parameter int reg_width = 16
);
    logic                 clk_en_i;
    logic [reg_width-1:0] vecreg_i;
    logic                 freeze_i;
    logic [reg_width-1:0] vecreg_o;
    logic                 update_o;
    logic                 pending_o;

    modport master (
        output clk_en_i,
        output vecreg_i,
        output freeze_i,
        input  vecreg_o,
        input  update_o,
        input  pending_o
    );

    modport slave (
        input  clk_en_i,
        input  vecreg_i,
        input  freeze_i,
        output vecreg_o,
        output update_o,
        output pending_o
    );
endinterface

// File: rtl/vector_stable_sync.sv
// Multi-bit synchroniser for an unclocked status/config vector: per-bit flop chain, then a whole-word
// stability filter that commits only after stable_cycles matching samples, with freeze and update strobe.
module vector_stable_sync #(
    parameter int                   reg_width     = 16,
    parameter logic [reg_width-1:0] reg_preset    = '0,
    parameter int                   resync_stages = 2,
    parameter int                   stable_cycles = 4
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    vector_stable_sync_if.slave  bus
);
    localparam int              CntW   = $clog2(stable_cycles) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(stable_cycles - 1);

    logic [reg_width-1:0] r_sync [resync_stages];
    logic [reg_width-1:0] r_cand;
    logic [reg_width-1:0] r_vec;
    logic [CntW-1:0]      r_cnt;
    logic                 r_upd;

    logic [reg_width-1:0] w_s;
    logic                 w_match;
    logic                 w_commit;

    // Stage 0 may go metastable; only the last stage feeds any decision logic.
    assign w_s      = r_sync[resync_stages-1];
    assign w_match  = (w_s == r_cand);
    assign w_commit = bus.clk_en_i && w_match && (r_cnt == CntMax)
                      && (r_cand != r_vec) && !bus.freeze_i;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int i = 0; i < resync_stages; i++) begin
                r_sync[i] <= reg_preset;
            end
        end else if (bus.clk_en_i) begin
            r_sync[0] <= bus.vecreg_i;
            for (int i = 1; i < resync_stages; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Any change at the synchroniser output restarts the stability window; the count saturates
    // so a frozen, stable candidate commits on the first unfrozen enabled edge.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_cand <= reg_preset;
            r_cnt  <= '0;
        end else if (bus.clk_en_i) begin
            if (!w_match) begin
                r_cand <= w_s;
                r_cnt  <= '0;
            end else if (r_cnt != CntMax) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_vec <= reg_preset;
            r_upd <= 1'b0;
        end else begin
            r_upd <= w_commit;
            if (w_commit) begin
                r_vec <= r_cand;
            end
        end
    end

    assign bus.vecreg_o  = r_vec;
    assign bus.update_o  = r_upd;
    assign bus.pending_o = (r_cand != r_vec);
endmodule

// File: tb/tb_vector_stable_sync.sv
// Bench for vector_stable_sync: directed scenarios plus randomized traffic, checked by a scoreboard
// fed from a sample-history reference model.
module tb_vector_stable_sync;
    localparam int          W   = 16;
    localparam int          R   = 2;
    localparam int          S   = 4;
    localparam logic [W-1:0] PRE = 16'hA5A5;

    logic clk_i  = 1'b0;
    logic nrst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    vector_stable_sync_if #(.reg_width(W)) bus();

    vector_stable_sync #(
        .reg_width(W), .reg_preset(PRE), .resync_stages(R), .stable_cycles(S)
    ) dut (
        .clk_i (clk_i),
        .nrst_i(nrst_i),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: a committed word is one that appeared as the synchroniser output
    // (the input sample R enabled edges earlier) on S+1 consecutive enabled edges.
    typedef struct packed {
        logic [W-1:0] vo;
        logic         upd;
        logic         pend;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] commit_q[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] m_out;
    bit           m_upd;

    function automatic void m_clear();
        hist.delete();
        for (int i = 0; i < R + S + 1; i++) hist.push_back(PRE);
        m_out = PRE;
        m_upd = 1'b0;
    endfunction

    function automatic bit m_pend();
        return hist[hist.size()-1-R] != m_out;
    endfunction

    function automatic void m_edge(input bit en, input logic [W-1:0] vin, input bit frz);
        int           n;
        logic [W-1:0] sv;
        bit           stable;
        m_upd = 1'b0;
        if (en) begin
            n      = hist.size();
            sv     = hist[n-R];
            stable = 1'b1;
            for (int i = n - R - S; i < n - R; i++) if (hist[i] != sv) stable = 1'b0;
            if (stable && sv != m_out && !frz) begin
                m_out = sv;
                m_upd = 1'b1;
                commit_q.push_back(sv);
            end
            hist.push_back(vin);
            if (hist.size() > 64) void'(hist.pop_front());
        end
    endfunction

    function automatic exp_t m_snap();
        exp_t e;
        e.vo   = m_out;
        e.upd  = m_upd;
        e.pend = m_pend();
        return e;
    endfunction

    always @(posedge clk_i) begin
        if (!nrst_i) m_clear();
        else m_edge(bus.clk_en_i, bus.vecreg_i, bus.freeze_i);
        exp_q.push_back(m_snap());
    end

    // Reset asserted mid-cycle replaces this cycle's expectation with the preset state.
    always @(negedge nrst_i) begin
        if (m_upd && commit_q.size() > 0) void'(commit_q.pop_back());
        m_clear();
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            exp_q.push_back(m_snap());
        end
    end

    always @(negedge clk_i) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow: no expectation queued at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("sb_vecreg", bus.vecreg_o, e.vo);
            chk("sb_update", bus.update_o, e.upd);
            chk("sb_pending", bus.pending_o, e.pend);
        end
        if (bus.update_o === 1'b1) begin
            if (commit_q.size() == 0) begin
                n_checks++;
                $display("FAIL commit_unexpected: update with vecreg %h, none expected", bus.vecreg_o);
            end else begin
                chk("commit_value", bus.vecreg_o, commit_q.pop_front());
            end
        end
    end

    // All tasks start and end at posedge+2, where inputs are changed.
    task automatic run(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(posedge clk_i); #1;
            if (bus.update_o === 1'b1) pulses++;
            #1;
        end
    endtask

    task automatic wait_update(input bit tog, input int budget, output int edges);
        int k = 0;
        edges = -1;
        while (k < budget) begin
            @(posedge clk_i); #1;
            k++;
            if (bus.update_o === 1'b1) begin
                edges = k;
                break;
            end
            #1;
            if (tog) bus.clk_en_i = ~bus.clk_en_i;
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int edges;
        logic [W-1:0] v;
        bus.vecreg_i = PRE;
        bus.clk_en_i = 1'b1;
        bus.freeze_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 nrst_i = 1'b1;

        chk("rst_vecreg", bus.vecreg_o, PRE);
        chk("rst_update", bus.update_o, 1'b0);
        chk("rst_pending", bus.pending_o, 1'b0);
        run(20, p);
        chk("idle_pulses", p, 0);
        chk("idle_vecreg", bus.vecreg_o, PRE);

        bus.vecreg_i = 16'h0000;
        wait_update(1'b0, 20, edges);
        chk("to_zero_latency", edges, 7);
        run(5, p);

        bus.vecreg_i = 16'h1234;
        wait_update(1'b0, 20, edges);
        chk("step_latency", edges, 7);
        chk("step_vecreg", bus.vecreg_o, 16'h1234);
        chk("step_pending", bus.pending_o, 1'b0);
        run(1, p);
        chk("step_pulse_width", p, 0);

        bus.vecreg_i = 16'h0000;
        wait_update(1'b0, 20, edges);
        run(5, p);
        bus.vecreg_i = 16'hFFFF;
        run(3, p);
        bus.vecreg_i = 16'h0000;
        run(15, p);
        chk("glitch_pulses", p, 0);
        chk("glitch_vecreg", bus.vecreg_o, 16'h0000);
        chk("glitch_pending", bus.pending_o, 1'b0);

        bus.freeze_i = 1'b1;
        bus.vecreg_i = 16'h00FF;
        run(20, p);
        chk("freeze_pulses", p, 0);
        chk("freeze_pending", bus.pending_o, 1'b1);
        chk("freeze_vecreg", bus.vecreg_o, 16'h0000);
        bus.freeze_i = 1'b0;
        run(1, p);
        chk("release_pulse", p, 1);
        chk("release_vecreg", bus.vecreg_o, 16'h00FF);

        bus.clk_en_i = 1'b0;
        bus.vecreg_i = 16'hBEEF;
        wait_update(1'b1, 40, edges);
        bus.clk_en_i = 1'b1;
        chk("clken_latency", edges, 14);
        chk("clken_vecreg", bus.vecreg_o, 16'hBEEF);
        run(1, p);
        chk("clken_pulse_width", p, 0);

        bus.vecreg_i = 16'h1111;
        run(5, p);
        nrst_i = 1'b0;
        #1;
        chk("midrst_vecreg", bus.vecreg_o, PRE);
        chk("midrst_update", bus.update_o, 1'b0);
        chk("midrst_pending", bus.pending_o, 1'b0);
        bus.vecreg_i = PRE;
        run(3, p);
        nrst_i = 1'b1;
        run(20, p);
        chk("midrst_no_pulse", p, 0);
        chk("midrst_vecreg_after", bus.vecreg_o, PRE);

        v = PRE;
        repeat (80) begin
            case ($urandom_range(0, 3))
                0: v = PRE;
                1: v = 16'h0F0F;
                default: v = 16'($urandom);
            endcase
            bus.vecreg_i = v;
            bus.freeze_i = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(1, 9)) begin
                bus.clk_en_i = ($urandom_range(0, 7) != 0);
                @(posedge clk_i); #2;
            end
        end
        bus.freeze_i = 1'b0;
        bus.clk_en_i = 1'b1;
        run(15, p);
        @(negedge clk_i); #1;
        chk("commits_drained", commit_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vector_stable_sync.md
# vector_stable_sync

Single-clock synchroniser for a multi-bit status or configuration vector that arrives from a foreign or unclocked domain. It is used where no source-side clock or handshake is available. Each bit is resynchronised through a parametrised flop chain. The synchronised word must be identical for a parametrised number of consecutive enabled cycles before it is committed to the output, so a word is never torn across bits. A hold input defers commits during critical phases, and every commit raises a one-cycle update strobe.

## Interface
Parameters:
- reg_width, 16: vector width in bits, ≥1.
- reg_preset, {reg_width{1'b0}}: reset and power-up value of every internal word register and of vecreg_o.
- resync_stages, 2: depth of the per-bit synchroniser chain, ≥2.
- stable_cycles, 4: number of consecutive matching enabled samples required before a commit, ≥1.

Ports:
- clk_i  in  1  sole clock; all logic is on the rising edge.
- nrst_i  in  1  asynchronous, active-low reset.
- clk_en_i  in  1  clock enable; the datapath advances only on edges where this is 1.
- vecreg_i  in  reg_width  asynchronous input vector.
- freeze_i  in  1  synchronous to clk_i; while 1, commits are inhibited.
- vecreg_o  out  reg_width  committed, stable vector; registered.
- update_o  out  1  one-clk_i-cycle pulse following each commit; registered.
- pending_o  out  1  candidate word differs from vecreg_o; combinational from registers only.

## Operation
- Registers:
  - sync chain [resync_stages][reg_width]; s denotes the last stage.
  - cand [reg_width], the candidate word.
  - cnt, width clog2(stable_cycles)+1, saturating at stable_cycles-1.
  - vecreg_o and update_o.
- Reset, asynchronous while nrst_i=0: sync, cand and vecreg_o = reg_preset; cnt = 0; update_o = 0. Initial values are identical for power-up without a reset.
- On every edge with clk_en_i=1, in priority order:
  1. The sync chain shifts; stage 0 samples vecreg_i.
  2. If s != cand: cand <= s and cnt <= 0. No commit occurs on this edge.
  3. Else, if cnt == stable_cycles-1, cand != vecreg_o and freeze_i=0: commit. vecreg_o <= cand, update_o <= 1, cnt stays saturated.
  4. Else: cnt <= min(cnt+1, stable_cycles-1).
- On any edge where no commit occurs, update_o <= 0. This applies whatever the value of clk_en_i, so update_o is exactly one clk_i cycle wide.
- pending_o = (cand != vecreg_o).
- The entire word is compared and committed together; there is no per-bit commit.
- No commit occurs when cand == vecreg_o, so a change that reverts to the current output produces no strobe.
- freeze_i:
  - Blocks only step 3. Sampling and counting continue, and cnt saturates.
  - On release, a commit occurs on the first enabled edge where the commit conditions hold. This is immediate if cand has been stable.
- Reset mid-count or mid-freeze discards cand and cnt and restores vecreg_o to preset. Update_o is forced to 0 immediately.

## Timing
- Latency from the first enabled edge that samples a new stable value to the edge that updates vecreg_o: resync_stages + stable_cycles + 1 enabled edges. With the defaults this is 7.
- With clk_en_i=0, all state except update_o holds, and latency is counted in enabled edges only.
- update_o rises on the same edge that updates vecreg_o.
- Any input change within the stability window restarts the count at 0, measured at the synchroniser output.
- Input metastability is confined to sync stage 0. Only s, cand, vecreg_o and cnt drive logic.
- The source must hold a value for at least stable_cycles+1 enabled edges for it to be committed.
- With stable_cycles=1, the commit occurs on the edge after cand is loaded.

## Test plan
- Reset, with defaults and reg_preset=16'hA5A5: hold nrst_i=0, then release. Required: vecreg_o=16'hA5A5, update_o=0 and pending_o=0 for 20 idle cycles.
- Step, with clk_en_i=1 and freeze_i=0: vecreg_i changes from 16'h0000 to 16'h1234. Required: vecreg_o=16'h1234 after exactly 7 edges; update_o=1 for one cycle, then 0; pending_o=0 after the commit.
- Glitch: vecreg_i goes from 16'h0000 to 16'hFFFF for 3 cycles, then back to 16'h0000. Required: no update_o pulse, vecreg_o stays 16'h0000, and pending_o returns to 0.
- Freeze: freeze_i=1, vecreg_i changes to 16'h00FF and is held for 20 cycles. Required: no update and pending_o=1 throughout. After freeze_i drops, vecreg_o=16'h00FF and update_o pulses on the first edge.
- Clock enable: clk_en_i toggles every other cycle and a step to 16'hBEEF is applied. Required: the commit follows 7 enabled edges, which is 14 clk_i cycles, and update_o is high for exactly one clk_i cycle.
- Reset mid-operation: nrst_i is asserted at cnt=2 during a pending change. Required: outputs return to preset immediately and asynchronously, and no update_o pulse follows the release of reset.
